// File: rtl/sc_mux_scan.sv
// sc_mux_scan: N-channel registered data selector with direct (clamped select) and auto-scan modes.
// Latency: 1 cycle from data/select to z; z and channel always describe the same channel.
// Backpressure: none; a new selection is registered every cycle, hold only freezes the scan position.
//
// Ports:
//   SC_MUXSCAN_CLOCK_50        rising-edge clock
//   SC_MUXSCAN_RESET_InHigh    synchronous active-high reset, highest priority
//   SC_MUXSCAN_data_InBUS      packed channels, channel k at [k*W +: W]
//   SC_MUXSCAN_select_InBUS    channel index in direct mode (out of range clamps to N-1)
//   SC_MUXSCAN_mode_In         0 = direct, 1 = scan
//   SC_MUXSCAN_dwell_InBUS     cycles per scanned channel minus 1
//   SC_MUXSCAN_hold_In         freeze scan position
//   SC_MUXSCAN_chmask_InBUS    (SC_MUXSCAN_CHMASK_EN only) per-channel scan enable
//   SC_MUXSCAN_z_OutBUS        registered selected data
//   SC_MUXSCAN_channel_OutBUS  index of the channel currently on z
//   SC_MUXSCAN_valid_Out       high on every edge after reset
//   SC_MUXSCAN_wrap_Out        one-cycle pulse when the scan returns to its first channel
// Optional build macro: SC_MUXSCAN_CHMASK_EN adds the channel mask (undefined: all channels scanned).

module sc_mux_scan #(
   parameter int NUMBER_DATAWIDTH  = 8,
   parameter int NUMBER_CHANNELS   = 10,
   parameter int NUMBER_SELWIDTH   = 4,
   parameter int NUMBER_DWELLWIDTH = 8
) (
   input  logic                                        SC_MUXSCAN_CLOCK_50,
   input  logic                                        SC_MUXSCAN_RESET_InHigh,
   input  logic [NUMBER_CHANNELS*NUMBER_DATAWIDTH-1:0] SC_MUXSCAN_data_InBUS,
   input  logic [NUMBER_SELWIDTH-1:0]                  SC_MUXSCAN_select_InBUS,
   input  logic                                        SC_MUXSCAN_mode_In,
   input  logic [NUMBER_DWELLWIDTH-1:0]                SC_MUXSCAN_dwell_InBUS,
   input  logic                                        SC_MUXSCAN_hold_In,
`ifdef SC_MUXSCAN_CHMASK_EN
   input  logic [NUMBER_CHANNELS-1:0]                  SC_MUXSCAN_chmask_InBUS,
`endif
   output logic [NUMBER_DATAWIDTH-1:0]                 SC_MUXSCAN_z_OutBUS,
   output logic [NUMBER_SELWIDTH-1:0]                  SC_MUXSCAN_channel_OutBUS,
   output logic                                        SC_MUXSCAN_valid_Out,
   output logic                                        SC_MUXSCAN_wrap_Out
);

   typedef enum logic {STATE_DIRECT, STATE_SCAN} stateType;

   localparam logic [NUMBER_SELWIDTH-1:0] LAST_CH = NUMBER_SELWIDTH'(NUMBER_CHANNELS - 1);

   stateType                     stateReg, stateNxt;
   logic [NUMBER_DWELLWIDTH-1:0] cntReg, cntNxt;
   logic [NUMBER_SELWIDTH-1:0]   nxtCh;
   logic [NUMBER_SELWIDTH-1:0]   advCh;     // channel a scan advance moves to
   logic [NUMBER_SELWIDTH-1:0]   firstCh;   // channel a scan starts on
   logic                         advWrap;   // an advance to advCh passes the top of the scan
   logic                         wrapNxt;
   logic [NUMBER_DATAWIDTH-1:0]  chanData [NUMBER_CHANNELS];

   for (genvar g = 0; g < NUMBER_CHANNELS; g++) begin : g_unpack
      assign chanData[g] = SC_MUXSCAN_data_InBUS[g*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH];
   end

`ifdef SC_MUXSCAN_CHMASK_EN
   logic [NUMBER_SELWIDTH-1:0] cand;
   logic                       found;

   // Search the enabled channels circularly starting just above the current one.
   // An empty mask leaves advCh on the current channel with no wrap.
   always_comb begin
      firstCh = '0;
      advCh   = SC_MUXSCAN_channel_OutBUS;
      found   = 1'b0;
      cand    = '0;
      for (int k = NUMBER_CHANNELS - 1; k >= 0; k--) begin
         if (SC_MUXSCAN_chmask_InBUS[k]) firstCh = NUMBER_SELWIDTH'(k);
      end
      for (int i = 1; i <= NUMBER_CHANNELS; i++) begin
         if (int'(SC_MUXSCAN_channel_OutBUS) + i >= NUMBER_CHANNELS)
            cand = NUMBER_SELWIDTH'(int'(SC_MUXSCAN_channel_OutBUS) + i - NUMBER_CHANNELS);
         else
            cand = NUMBER_SELWIDTH'(int'(SC_MUXSCAN_channel_OutBUS) + i);
         if (!found && SC_MUXSCAN_chmask_InBUS[cand]) begin
            found = 1'b1;
            advCh = cand;
         end
      end
      advWrap = found && (advCh <= SC_MUXSCAN_channel_OutBUS);
   end
`else
   assign firstCh = '0;
   assign advWrap = (SC_MUXSCAN_channel_OutBUS >= LAST_CH);
   assign advCh   = advWrap ? '0 : SC_MUXSCAN_channel_OutBUS + 1'b1;
`endif

   // Next-channel selection. mode=0 always wins and applies the direct rule on the
   // same edge, so leaving scan never costs a cycle.
   always_comb begin
      stateNxt = stateReg;
      cntNxt   = cntReg;
      nxtCh    = SC_MUXSCAN_channel_OutBUS;
      wrapNxt  = 1'b0;
      if (!SC_MUXSCAN_mode_In) begin
         stateNxt = STATE_DIRECT;
         cntNxt   = '0;
         nxtCh    = (SC_MUXSCAN_select_InBUS > LAST_CH) ? LAST_CH : SC_MUXSCAN_select_InBUS;
      end else if (stateReg == STATE_DIRECT) begin
         stateNxt = STATE_SCAN;
         cntNxt   = '0;
         nxtCh    = firstCh;
      end else if (SC_MUXSCAN_hold_In) begin
         // position and dwell count frozen; z still refreshes from live data
      end else if (cntReg < SC_MUXSCAN_dwell_InBUS) begin
         cntNxt = cntReg + 1'b1;
      end else begin
         // >= so that lowering dwell mid-period advances immediately
         cntNxt  = '0;
         nxtCh   = advCh;
         wrapNxt = advWrap;
      end
   end

   always_ff @(posedge SC_MUXSCAN_CLOCK_50) begin
      if (SC_MUXSCAN_RESET_InHigh) begin
         stateReg                  <= STATE_DIRECT;
         cntReg                    <= '0;
         SC_MUXSCAN_channel_OutBUS <= '0;
         SC_MUXSCAN_z_OutBUS       <= '0;
         SC_MUXSCAN_valid_Out      <= 1'b0;
         SC_MUXSCAN_wrap_Out       <= 1'b0;
      end else begin
         stateReg                  <= stateNxt;
         cntReg                    <= cntNxt;
         SC_MUXSCAN_channel_OutBUS <= nxtCh;
         SC_MUXSCAN_z_OutBUS       <= chanData[nxtCh];
         SC_MUXSCAN_valid_Out      <= 1'b1;
         SC_MUXSCAN_wrap_Out       <= wrapNxt;
      end
   end

endmodule

// File: tb/tb_sc_mux_scan.sv
// Testbench for sc_mux_scan (N=10, W=8): vector table, hand-written multi-cycle
// sequences, and randomized stimulus against a behavioural model.
// Build with SC_MUXSCAN_CHMASK_EN defined to also exercise the channel mask.

module tb_sc_mux_scan;

   localparam int N = 10;

   typedef struct {
      logic       rst;
      logic       mode;
      logic [3:0] sel;
      logic [7:0] dwell;
      logic       hold;
      logic [7:0] expZ;
      logic [3:0] expCh;
      logic       expV;
      logic       expW;
   } vecType;

   logic        clk;
   logic        rst;
   logic [79:0] dataBus;
   logic [7:0]  dataArr [N];
   logic [3:0]  sel;
   logic        mode;
   logic [7:0]  dwell;
   logic        hold;
   logic [7:0]  z;
   logic [3:0]  channel;
   logic        valid;
   logic        wrap;
`ifdef SC_MUXSCAN_CHMASK_EN
   logic [9:0]  chmask;
`endif

   int tests = 0;
   int fails = 0;

   // behavioural model state
   int  mCh, mCnt, mZ;
   bit  mScan, mV, mW;

   vecType vecs [17];

   sc_mux_scan dut (
      .SC_MUXSCAN_CLOCK_50       (clk),
      .SC_MUXSCAN_RESET_InHigh   (rst),
      .SC_MUXSCAN_data_InBUS     (dataBus),
      .SC_MUXSCAN_select_InBUS   (sel),
      .SC_MUXSCAN_mode_In        (mode),
      .SC_MUXSCAN_dwell_InBUS    (dwell),
      .SC_MUXSCAN_hold_In        (hold),
`ifdef SC_MUXSCAN_CHMASK_EN
      .SC_MUXSCAN_chmask_InBUS   (chmask),
`endif
      .SC_MUXSCAN_z_OutBUS       (z),
      .SC_MUXSCAN_channel_OutBUS (channel),
      .SC_MUXSCAN_valid_Out      (valid),
      .SC_MUXSCAN_wrap_Out       (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      dataBus = '0;
      for (int k = 0; k < N; k++) dataBus[k*8 +: 8] = dataArr[k];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] eZ, input logic [3:0] eCh,
                        input logic eV, input logic eW);
      tests++;
      if (z !== eZ || channel !== eCh || valid !== eV || wrap !== eW) begin
         fails++;
         $display("FAIL %s: got z=%h ch=%0d valid=%b wrap=%b, want z=%h ch=%0d valid=%b wrap=%b",
                  name, z, channel, valid, wrap, eZ, eCh, eV, eW);
      end
   endtask

   function automatic vecType mk(input logic r, input logic m, input logic [3:0] s,
                                 input logic [7:0] d, input logic h, input logic [7:0] ez,
                                 input logic [3:0] ec, input logic ev, input logic ew);
      vecType v;
      v.rst = r; v.mode = m; v.sel = s; v.dwell = d; v.hold = h;
      v.expZ = ez; v.expCh = ec; v.expV = ev; v.expW = ew;
      return v;
   endfunction

   task automatic doReset();
      rst = 1'b1; mode = 1'b0; sel = '0; dwell = '0; hold = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Model of one clock edge, written straight from the behavioural rules.
   task automatic modelEdge();
      if (rst) begin
         mZ = 0; mCh = 0; mV = 0; mW = 0; mScan = 0; mCnt = 0;
      end else begin
         mV = 1; mW = 0;
         if (!mode) begin
            mScan = 0; mCnt = 0;
            mCh = (int'(sel) < N) ? int'(sel) : N - 1;
         end else if (!mScan) begin
            mScan = 1; mCnt = 0; mCh = 0;
         end else if (hold) begin
            // frozen
         end else if (mCnt < int'(dwell)) begin
            mCnt++;
         end else begin
            mCnt = 0;
            mW   = (mCh == N - 1);
            mCh  = (mCh + 1) % N;
         end
         mZ = int'(dataArr[mCh]);
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) dataArr[k] = 8'h10 + 8'(k);
`ifdef SC_MUXSCAN_CHMASK_EN
      chmask = '1;
`endif
      rst = 1'b1; mode = 1'b0; sel = '0; dwell = '0; hold = 1'b0;

      // ---------------- table-driven vectors ----------------
      vecs[0]  = mk(1, 0,  0, 0, 0, 8'h00, 0, 0, 0);
      vecs[1]  = mk(1, 0,  0, 0, 0, 8'h00, 0, 0, 0);
      vecs[2]  = mk(1, 0,  0, 0, 0, 8'h00, 0, 0, 0);
      vecs[3]  = mk(0, 0,  3, 0, 0, 8'h13, 3, 1, 0);
      vecs[4]  = mk(0, 0, 12, 0, 0, 8'h19, 9, 1, 0);
      vecs[5]  = mk(0, 0,  0, 0, 0, 8'h10, 0, 1, 0);
      vecs[6]  = mk(0, 0, 15, 0, 0, 8'h19, 9, 1, 0);
      vecs[7]  = mk(0, 1,  0, 0, 0, 8'h10, 0, 1, 0);
      vecs[8]  = mk(0, 1,  0, 0, 0, 8'h11, 1, 1, 0);
      vecs[9]  = mk(0, 1,  0, 0, 0, 8'h12, 2, 1, 0);
      vecs[10] = mk(0, 0,  5, 0, 0, 8'h15, 5, 1, 0);
      vecs[11] = mk(0, 1,  0, 1, 0, 8'h10, 0, 1, 0);
      vecs[12] = mk(0, 1,  0, 1, 0, 8'h10, 0, 1, 0);
      vecs[13] = mk(0, 1,  0, 1, 0, 8'h11, 1, 1, 0);
      vecs[14] = mk(0, 1,  0, 1, 1, 8'h11, 1, 1, 0);
      vecs[15] = mk(0, 1,  7, 1, 0, 8'h11, 1, 1, 0);
      vecs[16] = mk(0, 1,  0, 0, 0, 8'h12, 2, 1, 0);
      for (int i = 0; i < 17; i++) begin
         rst = vecs[i].rst; mode = vecs[i].mode; sel = vecs[i].sel;
         dwell = vecs[i].dwell; hold = vecs[i].hold;
         tick();
         check($sformatf("vec%0d", i), vecs[i].expZ, vecs[i].expCh, vecs[i].expV, vecs[i].expW);
      end

      // ---------------- full scan, dwell=2, wrap on edge 31 ----------------
      doReset();
      mode = 1'b1; dwell = 8'd2;
      for (int e = 1; e <= 31; e++) begin
         tick();
         check($sformatf("scan_e%0d", e), 8'h10 + 8'(((e - 1) / 3) % N),
               4'(((e - 1) / 3) % N), 1'b1, (e == 31));
      end

      // ---------------- hold at channel 4, cnt=1 ----------------
      doReset();
      mode = 1'b1; dwell = 8'd2;
      for (int e = 1; e <= 14; e++) tick();
      check("hold_pre", 8'h14, 4'd4, 1'b1, 1'b0);
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) dataArr[4] = 8'hAA;
         tick();
         check($sformatf("hold%0d", i), (i >= 2) ? 8'hAA : 8'h14, 4'd4, 1'b1, 1'b0);
      end
      hold = 1'b0;
      tick();
      check("hold_rel1", 8'hAA, 4'd4, 1'b1, 1'b0);
      tick();
      check("hold_rel2", 8'h15, 4'd5, 1'b1, 1'b0);
      dataArr[4] = 8'h14;

      // ---------------- reset mid-scan at channel 7 ----------------
      doReset();
      mode = 1'b1; dwell = 8'd0;
      for (int e = 1; e <= 8; e++) tick();
      check("mid_ch7", 8'h17, 4'd7, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      check("mid_rst", 8'h00, 4'd0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      check("mid_reenter", 8'h10, 4'd0, 1'b1, 1'b0);
      tick();
      check("mid_next", 8'h11, 4'd1, 1'b1, 1'b0);

`ifdef SC_MUXSCAN_CHMASK_EN
      // ---------------- channel mask ----------------
      doReset();
      chmask = 10'b0000100101; mode = 1'b1; dwell = 8'd0;
      begin
         int seqCh [5] = '{0, 2, 5, 0, 2};
         bit seqW  [5] = '{0, 0, 0, 1, 0};
         for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("mask%0d", i), 8'h10 + 8'(seqCh[i]), 4'(seqCh[i]), 1'b1, seqW[i]);
         end
      end
      chmask = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("mask0_%0d", i), 8'h12, 4'd2, 1'b1, 1'b0);
      end
      chmask = '1;
`endif

      // ---------------- randomized against the model ----------------
      rst = 1'b1; mode = 1'b0; sel = '0; dwell = '0; hold = 1'b0;
      tick();
      modelEdge();
      for (int c = 0; c < 600; c++) begin
         rst   = ($urandom_range(0, 49) == 0);
         mode  = ($urandom_range(0, 7) != 0);
         sel   = 4'($urandom_range(0, 15));
         dwell = 8'($urandom_range(0, 3));
         hold  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0) dataArr[$urandom_range(0, N - 1)] = 8'($urandom);
         tick();
         modelEdge();
         check($sformatf("rand%0d", c), 8'(mZ), 4'(mCh), mV, mW);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
